fe_target: RTL

FE_TARGET -- requirements
Module: fe_target

---
 rtl/libfedriver_pkg.sv | 31 +++
 rtl/fe_target_ram.sv | 40 ++++
 rtl/fe_target.sv | 109 ++++++++++
 3 files changed

// File: rtl/libfedriver_pkg.sv
// Shared frontend-driver types: request/response records, default lane
// geometry and the core-reset sequencer state encoding.
package libfedriver;

  localparam int FE_LANES  = 8;
  localparam int FE_ADDR_W = 11;
  localparam int FE_DATA_W = 16;

  typedef struct packed {
    logic                                  rst_in;
    logic [FE_LANES-1:0]                   we;
    logic [FE_ADDR_W-1:0]                  addr;
    logic [FE_LANES-1:0][FE_DATA_W-1:0]    data;
  } fedriver_request_type;

  typedef struct packed {
    logic [FE_LANES-1:0][FE_DATA_W-1:0]    data;
  } fedriver_response_type;

  typedef enum logic [1:0] {
    FE_RUN    = 2'd0,
    FE_ASSERT = 2'd1,
    FE_HOLD   = 2'd2
  } fe_state_e;

  // Hold counter load value: the counter runs RST_HOLD-1 down to 0 inclusive.
  function automatic logic [15:0] holdLoad(input int unsigned rstHold);
    return 16'(rstHold - 1);
  endfunction

endpackage

// File: rtl/fe_target_ram.sv
// Single-port write-first RAM, one per data lane. Contents are never
// cleared; only the registered read port is reset.
module fe_target_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array write; no reset so the contents survive a frontend reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read; a write in the same cycle forwards the new data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_we) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fe_target.sv
// Frontend target: LANES banks of lane RAM shared by one address, a write
// counter, and a core-reset sequencer that stretches rst_in by RST_HOLD cycles.
// LANES/ADDR_W/DATA_W must match the libfedriver geometry of the port types.
module fe_target
  import libfedriver::*;
#(
  parameter int LANES    = FE_LANES,
  parameter int ADDR_W   = FE_ADDR_W,
  parameter int DATA_W   = FE_DATA_W,
  parameter int RST_HOLD = 16
) (
  input  logic                  fe_clk,
  input  logic                  fe_rst_n,
  input  fedriver_request_type  fe_req,
  output fedriver_response_type fe_rep,
  output logic                  core_rst,
  output logic [31:0]           wr_count
);

  localparam logic [15:0] HOLD_LOAD = holdLoad(RST_HOLD);

  logic                         w_writeOk;
  logic [LANES-1:0]             w_laneWe;
  logic [LANES-1:0][DATA_W-1:0] w_rdata;
  fe_state_e                    r_state;
  fe_state_e                    w_stateNext;
  logic [15:0]                  r_holdCnt;
  logic [15:0]                  w_holdCntNext;
  logic                         r_coreRst;
  logic [31:0]                  r_wrCount;

  // rst_in and the frontend reset both veto writes; FSM state does not.
  assign w_writeOk = fe_rst_n & ~fe_req.rst_in;
  assign w_laneWe  = fe_req.we[LANES-1:0] & {LANES{w_writeOk}};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fe_target_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_ram (
      .i_clk   (fe_clk),
      .i_rst_n (fe_rst_n),
      .i_we    (w_laneWe[g]),
      .i_addr  (fe_req.addr[ADDR_W-1:0]),
      .i_wdata (fe_req.data[g]),
      .o_rdata (w_rdata[g])
    );
  end

  assign fe_rep.data = w_rdata;

  // Count cycles where at least one lane was actually written; wraps naturally.
  always_ff @(posedge fe_clk) begin
    if (!fe_rst_n) begin
      r_wrCount <= '0;
    end else if (|w_laneWe) begin
      r_wrCount <= r_wrCount + 32'd1;
    end
  end

  // Sequencer state register; core_rst is registered from the next state.
  always_ff @(posedge fe_clk) begin
    if (!fe_rst_n) begin
      r_state   <= FE_HOLD;
      r_holdCnt <= HOLD_LOAD;
      r_coreRst <= 1'b1;
    end else begin
      r_state   <= w_stateNext;
      r_holdCnt <= w_holdCntNext;
      r_coreRst <= (w_stateNext != FE_RUN);
    end
  end

  // Next-state logic: ASSERT while rst_in is high, then count HOLD down to 0.
  always_comb begin
    w_stateNext   = r_state;
    w_holdCntNext = r_holdCnt;
    case (r_state)
      FE_RUN: begin
        if (fe_req.rst_in) begin
          w_stateNext = FE_ASSERT;
        end
      end
      FE_ASSERT: begin
        if (!fe_req.rst_in) begin
          w_stateNext   = FE_HOLD;
          w_holdCntNext = HOLD_LOAD;
        end
      end
      FE_HOLD: begin
        if (fe_req.rst_in) begin
          w_stateNext = FE_ASSERT;
        end else if (r_holdCnt == 16'd0) begin
          w_stateNext = FE_RUN;
        end else begin
          w_holdCntNext = r_holdCnt - 16'd1;
        end
      end
      default: begin
        w_stateNext   = FE_HOLD;
        w_holdCntNext = HOLD_LOAD;
      end
    endcase
  end

  assign core_rst = r_coreRst;
  assign wr_count = r_wrCount;

endmodule
